// File: rtl/prg_cache.sv
// Direct-mapped read-only program cache for the NeonFox fetch port.
// Misses stall the core, burst-fill the whole line in order, then replay the fetch.
module prg_cache #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned LINES      = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] prg_address,
  output logic [15:0] prg_data,
  output logic        p_cache_miss,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_address,
  input  logic        mem_ack,
  input  logic        mem_valid,
  input  logic [15:0] mem_data
);

  localparam int unsigned OFS  = $clog2(LINE_WORDS);
  localparam int unsigned IDX  = $clog2(LINES);
  localparam int unsigned TAGW = 32 - IDX - OFS;

  typedef enum logic [1:0] {StLookup, StFill, StReplay} state_e;

  state_e                state_q, state_d;
  logic [31:0]           req_addr_q, req_addr_d;
  logic                  lookup_v_q, lookup_v_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [OFS-1:0]        cnt_q, cnt_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  mem_req_q, mem_req_d;
  logic                  acked_q, acked_d;
  logic [31:0]           mem_address_q, mem_address_d;
  logic [15:0]           rd_q;

  logic [TAGW-1:0]       tag_q [LINES];
  logic [15:0]           ram_q [LINES*LINE_WORDS];

  logic [IDX-1:0]        req_idx;
  logic [TAGW-1:0]       req_tag;
  logic                  hit;
  logic                  rd_en, wr_en, line_done;
  logic [IDX+OFS-1:0]    rd_addr, wr_addr;

  assign req_idx = req_addr_q[OFS +: IDX];
  assign req_tag = req_addr_q[31 -: TAGW];
  assign hit     = lookup_v_q & valid_q[req_idx] & (tag_q[req_idx] == req_tag);

  always_comb begin
    state_d       = state_q;
    req_addr_d    = req_addr_q;
    lookup_v_d    = lookup_v_q;
    valid_d       = valid_q;
    cnt_d         = cnt_q;
    flush_pend_d  = flush_pend_q;
    mem_req_d     = mem_req_q;
    acked_d       = acked_q;
    mem_address_d = mem_address_q;
    rd_en         = 1'b0;
    rd_addr       = prg_address[IDX+OFS-1:0];
    wr_en         = 1'b0;
    wr_addr       = {req_idx, cnt_q};
    line_done     = 1'b0;
    p_cache_miss  = 1'b0;

    unique case (state_q)
      StLookup: begin
        if (!lookup_v_q || hit) begin
          rd_en      = 1'b1;
          req_addr_d = prg_address;
          lookup_v_d = 1'b1;
        end else begin
          p_cache_miss  = 1'b1;
          mem_req_d     = 1'b1;
          acked_d       = 1'b0;
          mem_address_d = {req_addr_q[31:OFS], {OFS{1'b0}}};
          state_d       = StFill;
        end
        // Clearing here means the lookup sampled this edge sees the empty array.
        if (flush || flush_pend_q) begin
          valid_d      = '0;
          flush_pend_d = 1'b0;
        end
      end
      StFill: begin
        p_cache_miss = 1'b1;
        if (mem_req_q && mem_ack) begin
          mem_req_d = 1'b0;
          acked_d   = 1'b1;
        end
        // Words are only trusted once the request has been accepted.
        if (mem_valid && (acked_q || (mem_req_q && mem_ack))) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == OFS'(LINE_WORDS - 1)) begin
            line_done        = 1'b1;
            valid_d[req_idx] = 1'b1;
            state_d          = StReplay;
          end
        end
        if (flush) flush_pend_d = 1'b1;
      end
      StReplay: begin
        p_cache_miss = 1'b1;
        rd_en        = 1'b1;
        rd_addr      = req_addr_q[IDX+OFS-1:0];
        state_d      = StLookup;
        if (flush) flush_pend_d = 1'b1;
      end
      default: state_d = StLookup;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StLookup;
      req_addr_q    <= '0;
      lookup_v_q    <= 1'b0;
      valid_q       <= '0;
      cnt_q         <= '0;
      flush_pend_q  <= 1'b0;
      mem_req_q     <= 1'b0;
      acked_q       <= 1'b0;
      mem_address_q <= '0;
      rd_q          <= '0;
    end else begin
      state_q       <= state_d;
      req_addr_q    <= req_addr_d;
      lookup_v_q    <= lookup_v_d;
      valid_q       <= valid_d;
      cnt_q         <= cnt_d;
      flush_pend_q  <= flush_pend_d;
      mem_req_q     <= mem_req_d;
      acked_q       <= acked_d;
      mem_address_q <= mem_address_d;
      if (rd_en) rd_q <= ram_q[rd_addr];
    end
  end

  // Storage arrays carry no reset; validity is tracked by valid_q alone.
  always_ff @(posedge clk) begin
    if (wr_en) ram_q[wr_addr] <= mem_data;
    if (line_done) tag_q[req_idx] <= req_tag;
  end

  assign prg_data    = rd_q;
  assign mem_req     = mem_req_q;
  assign mem_address = mem_address_q;

endmodule

// File: tb/tb_prg_cache.sv
// Directed bench for prg_cache: cold miss, hits, eviction, flush, handshake stress, reset mid-fill.
module tb_prg_cache;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] prg_address;
  logic [15:0] prg_data;
  logic        p_cache_miss;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_address;
  logic        mem_ack;
  logic        mem_valid;
  logic [15:0] mem_data;

  int vectors = 0;
  int errors  = 0;

  prg_cache #(.LINE_WORDS(8), .LINES(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .prg_address  (prg_address),
    .prg_data     (prg_data),
    .p_cache_miss (p_cache_miss),
    .flush        (flush),
    .mem_req      (mem_req),
    .mem_address  (mem_address),
    .mem_ack      (mem_ack),
    .mem_valid    (mem_valid),
    .mem_data     (mem_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Memory side of one line fill; returns in the first LOOKUP cycle after REPLAY.
  task automatic fill(input logic [31:0] exp_addr, input logic [15:0] base, input int ack_dly,
                      input bit gappy, input bit stray, input bit flush_mid);
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    vectors++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL fill_req_wait: got mem_req %b after %0d cycles, expected 1", mem_req, n);
      return;
    end
    chk32("fill_mem_address", mem_address, exp_addr);
    if (stray) begin
      mem_valid = 1'b1;
      mem_data  = 16'hDEAD;
      cyc();
      mem_valid = 1'b0;
    end
    repeat (ack_dly) cyc();
    chk1("fill_req_held", mem_req, 1'b1);
    mem_ack = 1'b1;
    flush   = flush_mid;
    cyc();
    mem_ack = 1'b0;
    flush   = 1'b0;
    chk1("fill_req_drop", mem_req, 1'b0);
    chk1("fill_miss_high", p_cache_miss, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (gappy) repeat ($urandom_range(0, 2)) cyc();
      mem_valid = 1'b1;
      mem_data  = base + 16'(i);
      cyc();
      mem_valid = 1'b0;
    end
    chk1("replay_miss_high", p_cache_miss, 1'b1);
    cyc();
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    prg_address = 32'h10;
    flush       = 1'b0;
    mem_ack     = 1'b0;
    mem_valid   = 1'b0;
    mem_data    = '0;
    repeat (2) cyc();
    chk1("reset_mem_req", mem_req, 1'b0);
    chk32("reset_mem_address", mem_address, 32'h0);
    chk16("reset_prg_data", prg_data, 16'h0);
    chk1("reset_miss", p_cache_miss, 1'b0);
  endtask

  task automatic test_cold_start();
    reset_n = 1'b1;
    cyc();
    chk1("cold_miss_cycle1", p_cache_miss, 1'b1);
    fill(32'h10, 16'hA000, 0, 1'b0, 1'b0, 1'b0);
    chk1("cold_miss_low", p_cache_miss, 1'b0);
    chk16("cold_data", prg_data, 16'hA000);
  endtask

  task automatic test_seq_hits();
    for (int a = 'h11; a <= 'h17; a++) begin
      prg_address = 32'(a);
      cyc();
      chk1("seq_miss", p_cache_miss, 1'b0);
      chk16("seq_data", prg_data, 16'hA000 + 16'(a - 'h10));
    end
  endtask

  task automatic test_conflict();
    prg_address = 32'h110;
    cyc();
    chk1("conflict_miss1", p_cache_miss, 1'b1);
    fill(32'h110, 16'hB000, 1, 1'b0, 1'b0, 1'b0);
    chk16("conflict_data1", prg_data, 16'hB000);
    prg_address = 32'h10;
    cyc();
    chk1("conflict_miss2", p_cache_miss, 1'b1);
    fill(32'h10, 16'hA000, 0, 1'b0, 1'b0, 1'b0);
    chk16("conflict_data2", prg_data, 16'hA000);
  endtask

  task automatic test_flush();
    prg_address = 32'h12;
    cyc();
    chk1("flush_prehit_miss", p_cache_miss, 1'b0);
    chk16("flush_prehit_data", prg_data, 16'hA002);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk1("flush_lookup_miss", p_cache_miss, 1'b1);
    fill(32'h10, 16'hC000, 2, 1'b0, 1'b0, 1'b1);
    chk1("flush_fill_replay_miss", p_cache_miss, 1'b0);
    chk16("flush_fill_replay_data", prg_data, 16'hC002);
    prg_address = 32'h13;
    cyc();
    chk1("flush_pend_miss", p_cache_miss, 1'b1);
    fill(32'h10, 16'hC000, 0, 1'b0, 1'b0, 1'b0);
    chk16("flush_refill_data", prg_data, 16'hC003);
  endtask

  task automatic test_handshake();
    prg_address = 32'h200;
    cyc();
    chk1("hs_miss", p_cache_miss, 1'b1);
    fill(32'h200, 16'hD000, 5, 1'b1, 1'b1, 1'b0);
    chk1("hs_miss_low", p_cache_miss, 1'b0);
    chk16("hs_word0", prg_data, 16'hD000);
    for (int a = 'h201; a <= 'h207; a++) begin
      prg_address = 32'(a);
      cyc();
      chk1("hs_hit_miss", p_cache_miss, 1'b0);
      chk16("hs_word", prg_data, 16'hD000 + 16'(a - 'h200));
    end
  endtask

  task automatic test_reset_midfill();
    int n = 0;
    prg_address = 32'h300;
    cyc();
    chk1("rmf_miss", p_cache_miss, 1'b1);
    while (mem_req !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    chk32("rmf_mem_address", mem_address, 32'h300);
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1'b1;
      mem_data  = 16'h5500 + 16'(i);
      cyc();
    end
    reset_n = 1'b0;
    #1;
    chk1("rmf_async_req", mem_req, 1'b0);
    chk1("rmf_async_miss", p_cache_miss, 1'b0);
    mem_data = 16'h5503;
    cyc();
    reset_n  = 1'b1;
    mem_data = 16'h5504;
    cyc();
    mem_valid = 1'b0;
    chk1("rmf_post_miss", p_cache_miss, 1'b1);
    fill(32'h300, 16'hE000, 1, 1'b0, 1'b0, 1'b0);
    chk16("rmf_word0", prg_data, 16'hE000);
    prg_address = 32'h303;
    cyc();
    chk16("rmf_word3", prg_data, 16'hE003);
    prg_address = 32'h307;
    cyc();
    chk1("rmf_word7_miss", p_cache_miss, 1'b0);
    chk16("rmf_word7", prg_data, 16'hE007);
  endtask

  initial begin
    test_reset();
    test_cold_start();
    test_seq_hits();
    test_conflict();
    test_flush();
    test_handshake();
    test_reset_midfill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/prg_cache.md
# prg_cache

Direct-mapped, read-only program cache between external program memory and the NeonFox core's fetch port.
- Returns one 16-bit instruction word per cycle on a hit.
- Raises `p_cache_miss` when the addressed line is absent or invalid.
- Fills the line from memory with an in-order burst, then replays the stalled fetch.
- Drives the core's `prg_data` and `p_cache_miss` inputs and consumes its `prg_address`.

## Interface
Parameters:
- `LINE_WORDS`, default 8: 16-bit words per line; power of two, ≥2. `OFS = log2(LINE_WORDS)`.
- `LINES`, default 32: number of lines; power of two, ≥2. `IDX = log2(LINES)`. Tag width is `32 - IDX - OFS`.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `prg_address` in 32: word address from the core, sampled every cycle not stalled by a miss.
- `prg_data` out 16: instruction word for the previously sampled address.
- `p_cache_miss` out 1: `prg_data` invalid; the core must hold `prg_address` while high.
- `flush` in 1: one-cycle pulse that invalidates all lines.
- `mem_req` out 1: burst read request, held until acknowledged.
- `mem_address` out 32: line base address, `{req_addr[31:OFS], OFS'b0}`.
- `mem_ack` in 1: memory accepted the request.
- `mem_valid` in 1: `mem_data` carries the next burst word.
- `mem_data` in 16: burst data; words arrive in order, offset 0 first.

## Operation
- Storage:
  - Data RAM of `LINES*LINE_WORDS` x16 with synchronous read, addressed `{idx, ofs}`.
  - Tag register array and valid bit array, read combinationally.
- `req_addr` register holds the address of the lookup in flight. `lookup_v` flags that `req_addr` is meaningful.
- Hit is `lookup_v & valid[req_addr idx] & (tag[idx] == req_addr tag)`.
- State machine:
  - LOOKUP:
    - On a hit: `p_cache_miss = 0`. `req_addr <= prg_address`, data RAM reads `prg_address`, `lookup_v <= 1`.
    - On `lookup_v & ~hit`: `p_cache_miss = 1`. `req_addr` holds, `mem_req <= 1`, go to FILL.
  - FILL:
    - `p_cache_miss = 1`. `mem_req` stays high until the cycle `mem_ack` is sampled high, then drops.
    - Each `mem_valid` writes `mem_data` to RAM `{idx, cnt}` and increments the OFS-bit `cnt`.
    - On the write with `cnt == LINE_WORDS-1`: set `tag[idx]` and `valid[idx]`, clear `cnt`, go to REPLAY.
    - `mem_valid` before `mem_ack` is ignored. `mem_valid` outside FILL is ignored.
  - REPLAY:
    - `p_cache_miss = 1`. Data RAM reads `req_addr`; go to LOOKUP.
    - The next cycle is a hit: `p_cache_miss = 0` and `prg_data` is valid.
- `p_cache_miss` decodes from state, `lookup_v` and the arrays only. There is no combinational path from `prg_address`.
- `flush`:
  - In LOOKUP: clears every valid bit at the clock edge. The lookup sampled on that edge is evaluated against the cleared array, so it misses.
  - In FILL or REPLAY: latched into `flush_pend`. The in-progress line completes and its replay still returns data. All valid bits clear on the first LOOKUP cycle, so the next fetch misses.
- Arithmetic: `cnt` wraps modulo `LINE_WORDS`. Index and tag fields are straight bit slices; no address arithmetic.

## Timing
- Reset (async, `reset_n` low):
  - State LOOKUP, `lookup_v = 0`, all valid bits 0, `cnt = 0`, `flush_pend = 0`.
  - Outputs: `mem_req = 0`, `mem_address = 0`, `prg_data = 0`, `p_cache_miss = 0`.
  - RAM and tag contents are don't-care.
- Hit latency: address presented in cycle N, `prg_data` valid in N+1. Throughput is 1 word/cycle.
- Miss penalty, with ack in A cycles and last word in W cycles after ack: `p_cache_miss` is high from cycle N+1 through the REPLAY cycle. `prg_data` is valid and `p_cache_miss` low in cycle N+3+A+W.
- Reset asserted mid-fill aborts immediately. Leftover burst words after release are ignored (state LOOKUP).
- Back-to-back misses on different lines each perform a full fill. No line is partially valid at any time.

## Test plan
- Cold start: release reset and fetch address 0x10 with `LINE_WORDS=8`.
  - `p_cache_miss = 1` from cycle 1, `mem_address = 0x10`, `mem_req` high until ack.
  - Return 0xA000..0xA007. `prg_data = 0xA000` and miss low after REPLAY.
- Sequential hits: fetch 0x11..0x17 one per cycle. `prg_data` is 0xA001..0xA007 one cycle later, `p_cache_miss` stays 0.
- Conflict eviction (`LINES=32`): fetch 0x10 then 0x110. Second fill uses `mem_address = 0x110`. Refetching 0x10 misses again with `mem_address = 0x10`.
- Flush: on a hit line at 0x12, pulse `flush` in LOOKUP. The next lookup misses. Pulsing `flush` during FILL still delivers the replayed word; the subsequent fetch of 0x13 misses.
- Handshake stress: delay `mem_ack` 5 cycles, gap `mem_valid` randomly, send a spurious `mem_valid` before ack.
  - Exactly 8 words are written, in order.
  - The stray word is discarded.
  - `mem_req` drops the cycle after ack.
- Reset mid-fill: assert `reset_n` low after 3 burst words.
  - `mem_req = 0` and `p_cache_miss = 0` immediately.
  - After release, the same address misses again and performs a complete fill.
